// File: rtl/dma_controller_pkg.sv
// ----------------------------------------------------------------------------
// dma_controller_pkg
//   Shared definitions for the DMA initiator and its bus driver:
//   word/line widths, the default transfer length and the controller
//   state encoding.
// ----------------------------------------------------------------------------
package dma_controller_pkg;

    // Data-path widths, matching the CPU's WORD_SIZE / LINE_SIZE.
    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned LINE_SIZE = 64;

    // Default transfer length, in lines.
    localparam int unsigned DMA_LENGTH = 3;

    // Default number of cycles the memory write strobe is held per line.
    localparam int unsigned DMA_WRITE_CYCLES = 2;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_BEGIN,
        DMA_CMD,
        DMA_REQ,
        DMA_WRITE,
        DMA_NEXT,
        DMA_DONE
    } dma_state_e;

endpackage : dma_controller_pkg

// File: rtl/dma_controller_bus_driver.sv
// ----------------------------------------------------------------------------
// dma_controller_bus_driver
//   Tri-state driver for the shared data-memory bus. Any bus-master
//   peripheral can reuse it: the owner computes a single enable (grant held
//   and in its write phase) and the driver either drives the strobe,
//   address and data or releases all three to z.
//
// Ports
//   en_i         drive enable (grant & write phase)
//   addr_i       address to present while enabled
//   data_i       write data to present while enabled
//   d_writeM_o   memory write strobe, 1 while enabled, else z
//   d_address_o  memory address, addr_i while enabled, else z
//   d_data_io    memory write data, data_i while enabled, else z
// ----------------------------------------------------------------------------
module dma_controller_bus_driver #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 64
) (
    input  logic                   en_i,
    input  logic      [ADDR_W-1:0] addr_i,
    input  logic      [DATA_W-1:0] data_i,
    output wire logic              d_writeM_o,
    output wire logic [ADDR_W-1:0] d_address_o,
    inout  wire logic [DATA_W-1:0] d_data_io
);

    assign d_writeM_o  = en_i ? 1'b1   : 1'bz;
    assign d_address_o = en_i ? addr_i : 'z;
    assign d_data_io   = en_i ? data_i : 'z;

endmodule : dma_controller_bus_driver

// File: rtl/dma_controller.sv
// ----------------------------------------------------------------------------
// dma_controller
//   Bus-master DMA initiator paired with the pipelined CPU. On a device
//   request it pulses dma_begin, latches the destination base address the
//   CPU supplies, requests the data bus, and once granted writes NUM_LINES
//   device lines to consecutive line addresses (base + 4*line, wrapping at
//   2^WORD_W). Each line holds d_writeM for WRITE_CYCLES cycles. Finally it
//   drops the bus request and pulses dma_end.
//
//   Losing the grant mid-line aborts that line; the controller re-requests
//   the bus and rewrites the same line in full.
//
// Build option
//   DMA_CYCLE_STEAL_EN  when defined, the bus request is dropped for one
//                       cycle between lines so the CPU may reclaim the bus;
//                       otherwise the bus is held for the whole block.
//
// Ports
//   Clk               clock
//   Reset_N           asynchronous active-low reset (aborts any transfer)
//   dev_req           device has a block ready (level, sampled in IDLE)
//   dev_line_sel      index of the line the device must present
//   dev_line          device line data for dev_line_sel
//   dma_begin         one-cycle pulse: transfer pending
//   dma_command_addr  destination base address from the CPU
//   dma_bus_request   bus request (BR) to the CPU
//   dma_bus_grant     bus grant (BG) from the CPU
//   dma_end           one-cycle pulse: transfer complete
//   d_writeM          memory write strobe, z unless bus owned and writing
//   d_address         memory address, z unless bus owned and writing
//   d_data            memory write data, z unless bus owned and writing
// ----------------------------------------------------------------------------
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int unsigned WORD_W       = WORD_SIZE,
    parameter int unsigned LINE_W       = LINE_SIZE,
    parameter int unsigned NUM_LINES    = DMA_LENGTH,
    parameter int unsigned WRITE_CYCLES = DMA_WRITE_CYCLES
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              dev_req,
    output logic      [1:0]        dev_line_sel,
    input  logic      [LINE_W-1:0] dev_line,
    output logic                   dma_begin,
    input  logic      [WORD_W-1:0] dma_command_addr,
    output logic                   dma_bus_request,
    input  logic                   dma_bus_grant,
    output logic                   dma_end,
    output wire logic              d_writeM,
    output wire logic [WORD_W-1:0] d_address,
    inout  wire logic [LINE_W-1:0] d_data
);

    localparam int unsigned CYC_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    localparam logic [1:0]        LAST_LINE   = 2'(NUM_LINES - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC    = CYC_W'(WRITE_CYCLES - 1);
    localparam logic [WORD_W-1:0] LINE_STRIDE = WORD_W'(LINE_W / WORD_W);

    dma_state_e        state_q, state_d;
    logic [1:0]        line_q,  line_d;
    logic [CYC_W-1:0]  cyc_q,   cyc_d;
    logic [WORD_W-1:0] base_q,  base_d;

    logic              write_phase;
    logic              bus_en;
    logic [WORD_W-1:0] bus_addr;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= DMA_IDLE;
            line_q  <= '0;
            cyc_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cyc_q   <= cyc_d;
            base_q  <= base_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        cyc_d           = cyc_q;
        base_d          = base_q;
        dma_begin       = 1'b0;
        dma_end         = 1'b0;
        dma_bus_request = 1'b0;
        write_phase     = 1'b0;

        case (state_q)
            DMA_IDLE: begin
                if (dev_req) begin
                    state_d = DMA_BEGIN;
                end
            end

            DMA_BEGIN: begin
                dma_begin = 1'b1;
                state_d   = DMA_CMD;
            end

            DMA_CMD: begin
                base_d  = dma_command_addr;
                line_d  = '0;
                cyc_d   = '0;
                state_d = DMA_REQ;
            end

            DMA_REQ: begin
                dma_bus_request = 1'b1;
                cyc_d           = '0;
                if (dma_bus_grant) begin
                    state_d = DMA_WRITE;
                end
            end

            DMA_WRITE: begin
                dma_bus_request = 1'b1;
                write_phase     = 1'b1;
                // A lost grant takes priority even on the last write cycle:
                // that cycle's strobe was already withdrawn, so the line
                // is incomplete and must be rewritten from its first cycle.
                if (!dma_bus_grant) begin
                    cyc_d   = '0;
                    state_d = DMA_REQ;
                end else if (cyc_q == LAST_CYC) begin
                    cyc_d   = '0;
                    state_d = DMA_NEXT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            DMA_NEXT: begin
                dma_bus_request = 1'b1;
                if (line_q == LAST_LINE) begin
                    state_d = DMA_DONE;
                end else begin
                    line_d = line_q + 1'b1;
`ifdef DMA_CYCLE_STEAL_EN
                    dma_bus_request = 1'b0;
                    state_d         = DMA_REQ;
`else
                    state_d         = DMA_WRITE;
`endif
                end
            end

            DMA_DONE: begin
                dma_end = 1'b1;
                line_d  = '0;
                state_d = DMA_IDLE;
            end

            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus drive
    // ------------------------------------------------------------------
    // Gating with the live grant releases the bus combinationally in the
    // cycle the CPU withdraws it, ahead of the state change on the next edge.
    assign bus_en       = dma_bus_grant && write_phase;
    assign bus_addr     = base_q + (WORD_W'(line_q) * LINE_STRIDE);
    assign dev_line_sel = line_q;

    dma_controller_bus_driver #(
        .ADDR_W (WORD_W),
        .DATA_W (LINE_W)
    ) u_bus_driver (
        .en_i        (bus_en),
        .addr_i      (bus_addr),
        .data_i      (dev_line),
        .d_writeM_o  (d_writeM),
        .d_address_o (d_address),
        .d_data_io   (d_data)
    );

endmodule : dma_controller

// File: tb/tb_dma_controller.sv
`timescale 1ns/1ps
module tb_dma_controller;

    localparam int unsigned WORD_W       = 16;
    localparam int unsigned LINE_W       = 64;
    localparam int unsigned NUM_LINES    = 3;
    localparam int unsigned WRITE_CYCLES = 2;
`ifdef DMA_CYCLE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset_N = 1'b0;
    logic              dev_req = 1'b0;
    logic [1:0]        dev_line_sel;
    logic [LINE_W-1:0] dev_line;
    logic              dma_begin;
    logic [WORD_W-1:0] dma_command_addr = '0;
    logic              dma_bus_request;
    logic              dma_bus_grant = 1'b0;
    logic              dma_end;
    wire               d_writeM;
    wire  [WORD_W-1:0] d_address;
    wire  [LINE_W-1:0] d_data;

    // Device model: four line buffers, selected combinationally.
    logic [LINE_W-1:0] dev_pat [4];
    assign dev_line = dev_pat[dev_line_sel];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    dma_controller #(
        .WORD_W       (WORD_W),
        .LINE_W       (LINE_W),
        .NUM_LINES    (NUM_LINES),
        .WRITE_CYCLES (WRITE_CYCLES)
    ) dut (
        .Clk              (Clk),
        .Reset_N          (Reset_N),
        .dev_req          (dev_req),
        .dev_line_sel     (dev_line_sel),
        .dev_line         (dev_line),
        .dma_begin        (dma_begin),
        .dma_command_addr (dma_command_addr),
        .dma_bus_request  (dma_bus_request),
        .dma_bus_grant    (dma_bus_grant),
        .dma_end          (dma_end),
        .d_writeM         (d_writeM),
        .d_address        (d_address),
        .d_data           (d_data)
    );

    typedef struct {
        logic [15:0]       base;
        int unsigned       gdelay;
        int                drop_line;
        logic [2:0][15:0]  exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One full transfer. The bench plays the CPU: BG rises once BR has been
    // seen high for more than gdelay sampled cycles, follows BR down, and
    // optionally withdraws BG for a few cycles on the first write cycle of
    // drop_line. Writes are grouped into runs of consecutive strobe cycles at
    // one address; a run of WRITE_CYCLES is a completed line.
    task automatic run_xfer(input logic [15:0] base, input int unsigned gdelay,
                            input int drop_line, input logic [2:0][15:0] exp_addr);
        int unsigned cyc = 0, begin_cnt = 0, begin_at = 0, end_cnt = 0, end_at = 0;
        int unsigned gaps = 0, aborted = 0, drive_viol = 0, data_err = 0;
        int unsigned br_cnt = 0, hold = 0, blen = 0, post = 0, exp_lat;
        logic [15:0] comp [$];
        logic [15:0] abort_addr = '0, baddr = '0, idx;
        logic        br_at_end = 1'b1;
        bit          in_b = 0, seen_br = 0, dropped = 0, done = 0, w;

        for (int i = 0; i < 4; i++) dev_pat[i] = {$urandom, $urandom};
        dma_command_addr = base;
        @(negedge Clk);
        dev_req       = 1'b1;
        dma_bus_grant = 1'b0;

        while (!done && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            w   = (d_writeM === 1'b1);
            idx = d_address - base;

            if (dma_begin === 1'b1) begin
                begin_cnt++;
                if (begin_cnt == 1) begin_at = cyc;
            end
            if (dma_end === 1'b1) begin
                end_cnt++;
                if (end_cnt == 1) begin
                    end_at    = cyc;
                    br_at_end = dma_bus_request;
                end
            end
            if (dma_bus_request === 1'b1) seen_br = 1;
            else if (seen_br && end_cnt == 0) gaps++;

            if (w && !dma_bus_grant) drive_viol++;
            if (w) begin
                if (idx[1:0] != 2'b00 || (idx >> 2) >= 16'(NUM_LINES) ||
                    d_data !== dev_pat[idx[3:2]] || dev_line_sel !== idx[3:2])
                    data_err++;
            end

            if (in_b && (!w || d_address !== baddr)) begin
                if (blen == WRITE_CYCLES) comp.push_back(baddr);
                else begin
                    aborted++;
                    abort_addr = baddr;
                end
                in_b = 0;
            end
            if (w) begin
                if (in_b) blen++;
                else begin
                    in_b  = 1;
                    baddr = d_address;
                    blen  = 1;
                end
            end

            if (end_cnt != 0) begin
                dev_req = 1'b0;
                post++;
                if (post > 3) done = 1;
            end

            if (drop_line >= 0 && !dropped && w && (idx >> 2) == 16'(drop_line)) begin
                dropped       = 1;
                dma_bus_grant = 1'b0;
                hold          = 3;
                br_cnt        = 0;
            end else if (hold > 0) begin
                hold--;
                dma_bus_grant = 1'b0;
            end else if (dma_bus_request === 1'b1) begin
                br_cnt++;
                if (br_cnt > gdelay) dma_bus_grant = 1'b1;
            end else begin
                br_cnt        = 0;
                dma_bus_grant = 1'b0;
            end
        end
        dev_req       = 1'b0;
        dma_bus_grant = 1'b0;

        exp_lat = 3 + (STEAL ? NUM_LINES : 1) * (gdelay + 1) + NUM_LINES * (WRITE_CYCLES + 1);

        chk("begin_pulses", 64'(begin_cnt), 64'd1);
        chk("begin_at", 64'(begin_at), 64'd1);
        chk("end_pulses", 64'(end_cnt), 64'd1);
        chk("br_low_at_end", 64'(br_at_end), 64'd0);
        if (drop_line < 0) chk("latency", 64'(end_at), 64'(exp_lat));
        chk("lines_done", 64'(comp.size()), 64'(NUM_LINES));
        for (int i = 0; i < int'(NUM_LINES); i++)
            chk($sformatf("line%0d_addr", i), (i < comp.size()) ? 64'(comp[i]) : 64'hBAD0_0000, 64'(exp_addr[i]));
        chk("aborted_lines", 64'(aborted), (drop_line >= 0) ? 64'd1 : 64'd0);
        if (drop_line >= 0) chk("abort_addr", 64'(abort_addr), 64'(exp_addr[drop_line]));
        chk("drive_without_grant", 64'(drive_viol), 64'd0);
        chk("write_data", 64'(data_err), 64'd0);
        chk("br_gaps", 64'(gaps), STEAL ? 64'(NUM_LINES - 1) : 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        logic [2:0][15:0] ea;
        logic [15:0]      rbase;
        int               ends, act, found;

        tbl[0] = '{16'h0017, 1,  -1, {16'h001F, 16'h001B, 16'h0017}};  // basic burst
        tbl[1] = '{16'h0017, 10, -1, {16'h001F, 16'h001B, 16'h0017}};  // delayed grant
        tbl[2] = '{16'h0017, 1,   1, {16'h001F, 16'h001B, 16'h0017}};  // grant lost on line 1
        tbl[3] = '{16'hFFFC, 0,  -1, {16'h0004, 16'h0000, 16'hFFFC}};  // address wrap
        for (int i = 0; i < 4; i++) dev_pat[i] = '0;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_begin", 64'(dma_begin), 64'd0);
        chk("rst_br", 64'(dma_bus_request), 64'd0);
        chk("rst_end", 64'(dma_end), 64'd0);
        chk("rst_line_sel", 64'(dev_line_sel), 64'd0);
        chk("rst_writeM_released", 64'(d_writeM === 1'b1), 64'd0);
        Reset_N = 1'b1;
        repeat (2) @(negedge Clk);

        for (int t = 0; t < 4; t++) begin
            run_xfer(tbl[t].base, tbl[t].gdelay, tbl[t].drop_line, tbl[t].exp_addr);
            repeat (2) @(negedge Clk);
        end

        // Reset in the middle of line 0, grant still asserted.
        for (int i = 0; i < 4; i++) dev_pat[i] = {$urandom, $urandom};
        dma_command_addr = 16'h0040;
        @(negedge Clk);
        dev_req = 1'b1;
        found   = 0;
        for (int c = 0; c < 50 && found == 0; c++) begin
            @(negedge Clk);
            if (d_writeM === 1'b1) found = 1;
            else if (dma_bus_request === 1'b1) dma_bus_grant = 1'b1;
        end
        chk("abort_reached_write", 64'(found), 64'd1);
        Reset_N = 1'b0;
        dev_req = 1'b0;
        #1;
        chk("abort_writeM_released", 64'(d_writeM === 1'b1), 64'd0);
        chk("abort_br", 64'(dma_bus_request), 64'd0);
        chk("abort_end", 64'(dma_end), 64'd0);
        chk("abort_line_sel", 64'(dev_line_sel), 64'd0);
        dma_bus_grant = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_N = 1'b1;
        ends = 0;
        act  = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (dma_end === 1'b1) ends++;
            if (dma_begin === 1'b1 || dma_bus_request === 1'b1 || d_writeM === 1'b1) act++;
        end
        chk("abort_no_end", 64'(ends), 64'd0);
        chk("abort_stays_idle", 64'(act), 64'd0);
        run_xfer(16'h0017, 1, -1, {16'h001F, 16'h001B, 16'h0017});
        repeat (2) @(negedge Clk);

        // Randomized transfers against the address model.
        for (int r = 0; r < 6; r++) begin
            rbase = 16'($urandom);
            for (int i = 0; i < int'(NUM_LINES); i++) ea[i] = rbase + 16'(4 * i);
            run_xfer(rbase, $urandom_range(0, 4), int'($urandom_range(0, 3)) - 1, ea);
            repeat (2) @(negedge Clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dma_controller
